// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: opcode constants, the fetch
// state encoding, the default reset PC and the branch offset helper.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetchState_t;

  // Word offset of a branch: sign-extended immediate scaled to bytes.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/ready bus between the fetch stage and memory.
interface instr_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, taken branch or jump target.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instrIndex,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] pcPlus4,
  output logic [31:0] nextPc
);

  logic [31:0] jumpTarget;
  logic [31:0] branchTarget;

  assign pcPlus4      = pc + 32'd4;
  assign jumpTarget   = {pcPlus4[31:28], instrIndex, 2'b00};
  assign branchTarget = pcPlus4 + branchOffset(instrIndex[15:0]);

  // Jump is checked first so it wins when the decoder raises both.
  always_comb begin
    nextPc = pcPlus4;
    if (Jump) begin
      nextPc = jumpTarget;
    end else if (Branch && Zero) begin
      nextPc = branchTarget;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// MIPS fetch stage: holds the PC, fetches one word at a time over the imem
// handshake into the IR, and commits the next PC when the datapath retires it.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic               clock,
  input  logic               reset_n,
  instr_fetch_if.master      imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [5:0]         OpCode,
  output logic [31:0]        pc_plus4,
  input  logic               advance,
  input  logic               Jump,
  input  logic               Branch,
  input  logic               Zero,
  output logic [31:0]        retired
);

  localparam logic [31:0] PC_START = {RESET_PC[31:2], 2'b00};

  fetchState_t state;
  fetchState_t nextState;

  logic [31:0] pc;
  logic [31:0] nextPc;
  logic        fetchDone;
  logic        commit;

  next_pc_calc nextPcCalc (
    .pc         (pc),
    .instrIndex (instr[25:0]),
    .Jump       (Jump),
    .Branch     (Branch),
    .Zero       (Zero),
    .pcPlus4    (pc_plus4),
    .nextPc     (nextPc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = FETCH;
      FETCH:   if (imem.imem_ready) nextState = EXEC;
      EXEC:    if (advance) nextState = FETCH;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decode only the state register, so imem_req drops the moment
  // reset is asserted and never depends on same-cycle inputs.
  always_comb begin
    imem.imem_req = 1'b0;
    fetchDone     = 1'b0;
    commit        = 1'b0;
    case (state)
      FETCH: begin
        imem.imem_req = 1'b1;
        fetchDone     = imem.imem_ready;
      end
      EXEC: begin
        commit = advance;
      end
      default: begin
        imem.imem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= PC_START;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      retired     <= 32'd0;
    end else begin
      if (fetchDone) begin
        instr       <= imem.imem_data;
        instr_valid <= 1'b1;
      end else if (commit) begin
        pc          <= nextPc;
        instr_valid <= 1'b0;
        retired     <= retired + 32'd1;
      end
    end
  end

  assign imem.imem_addr = pc;
  assign OpCode         = instr[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a default-PC instance exercises handshake,
// branch/jump selection and reset; a second instance exercises PC wrap.
module tb_instr_fetch;

  logic clock;
  logic reset_n;

  instr_fetch_if busA ();
  instr_fetch_if busB ();

  logic [31:0] instrA, instrB;
  logic        validA, validB;
  logic [5:0]  opA, opB;
  logic [31:0] plus4A, plus4B;
  logic [31:0] retiredA, retiredB;
  logic        advA, jumpA, branchA, zeroA;
  logic        advB, jumpB, branchB, zeroB;

  int total;
  int bad;

  instr_fetch dutA (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem        (busA),
    .instr       (instrA),
    .instr_valid (validA),
    .OpCode      (opA),
    .pc_plus4    (plus4A),
    .advance     (advA),
    .Jump        (jumpA),
    .Branch      (branchA),
    .Zero        (zeroA),
    .retired     (retiredA)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFF)) dutB (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem        (busB),
    .instr       (instrB),
    .instr_valid (validB),
    .OpCode      (opB),
    .pc_plus4    (plus4B),
    .advance     (advB),
    .Jump        (jumpB),
    .Branch      (branchB),
    .Zero        (zeroB),
    .retired     (retiredB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Fetch one word on dutA and retire it with the given control flags.
  task automatic runInstr(input logic [31:0] word, input logic j,
                          input logic b, input logic z);
    busA.imem_ready = 1'b1;
    busA.imem_data  = word;
    step();
    busA.imem_ready = 1'b0;
    advA = 1'b1; jumpA = j; branchA = b; zeroA = z;
    step();
    advA = 1'b0; jumpA = 1'b0; branchA = 1'b0; zeroA = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total++; if (busA.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b expected 0", busA.imem_req); end
    total++; if (busA.imem_addr !== 32'h0040_0000) begin bad++; $display("[TB] FAIL reset_addr: got %h expected 00400000", busA.imem_addr); end
    total++; if (retiredA !== 32'd0) begin bad++; $display("[TB] FAIL reset_retired: got %h expected 0", retiredA); end
    total++; if (validA !== 1'b0 || instrA !== 32'd0 || opA !== 6'd0) begin bad++; $display("[TB] FAIL reset_ir: got valid=%b instr=%h op=%h expected 0/0/0", validA, instrA, opA); end
    total++; if (busB.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL reset_pc_mask: got %h expected fffffffc", busB.imem_addr); end
    reset_n = 1'b1;
    step();
    total++; if (busA.imem_req !== 1'b1 || busA.imem_addr !== 32'h0040_0000) begin bad++; $display("[TB] FAIL first_fetch: got req=%b addr=%h expected 1/00400000", busA.imem_req, busA.imem_addr); end
    total++; if (validA !== 1'b0 || retiredA !== 32'd0) begin bad++; $display("[TB] FAIL first_fetch_state: got valid=%b retired=%h expected 0/0", validA, retiredA); end
  endtask

  task automatic test_ready_same_cycle();
    busA.imem_ready = 1'b1;
    busA.imem_data  = 32'h0109_5020;
    step();
    busA.imem_ready = 1'b0;
    total++; if (validA !== 1'b1 || instrA !== 32'h0109_5020) begin bad++; $display("[TB] FAIL ir_load: got valid=%b instr=%h expected 1/01095020", validA, instrA); end
    total++; if (opA !== 6'd0 || busA.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL exec_outputs: got op=%h req=%b expected 0/0", opA, busA.imem_req); end
    total++; if (plus4A !== 32'h0040_0004) begin bad++; $display("[TB] FAIL pc_plus4: got %h expected 00400004", plus4A); end
    advA = 1'b1;
    step();
    advA = 1'b0;
    total++; if (busA.imem_addr !== 32'h0040_0004 || retiredA !== 32'd1) begin bad++; $display("[TB] FAIL first_retire: got addr=%h retired=%h expected 00400004/1", busA.imem_addr, retiredA); end
    total++; if (validA !== 1'b0 || busA.imem_req !== 1'b1) begin bad++; $display("[TB] FAIL refetch: got valid=%b req=%b expected 0/1", validA, busA.imem_req); end
  endtask

  task automatic test_branch();
    runInstr(32'h0810_0002, 1'b1, 1'b0, 1'b0);
    total++; if (busA.imem_addr !== 32'h0040_0008) begin bad++; $display("[TB] FAIL jump_to_8: got %h expected 00400008", busA.imem_addr); end
    runInstr(32'h1000_0003, 1'b0, 1'b1, 1'b1);
    total++; if (busA.imem_addr !== 32'h0040_0018) begin bad++; $display("[TB] FAIL branch_taken: got %h expected 00400018", busA.imem_addr); end
    runInstr(32'h0810_0002, 1'b1, 1'b0, 1'b0);
    runInstr(32'h1000_0003, 1'b0, 1'b1, 1'b0);
    total++; if (busA.imem_addr !== 32'h0040_000C) begin bad++; $display("[TB] FAIL branch_not_taken: got %h expected 0040000c", busA.imem_addr); end
    runInstr(32'h0810_0002, 1'b1, 1'b0, 1'b0);
    runInstr(32'h1000_FFFF, 1'b0, 1'b1, 1'b1);
    total++; if (busA.imem_addr !== 32'h0040_0008) begin bad++; $display("[TB] FAIL branch_backward: got %h expected 00400008", busA.imem_addr); end
    total++; if (retiredA !== 32'd7) begin bad++; $display("[TB] FAIL retired_count: got %0d expected 7", retiredA); end
  endtask

  task automatic test_jump_priority();
    runInstr(32'h0810_0000, 1'b1, 1'b1, 1'b1);
    total++; if (busA.imem_addr !== 32'h0040_0000) begin bad++; $display("[TB] FAIL jump_priority: got %h expected 00400000", busA.imem_addr); end
  endtask

  task automatic test_delayed_ready();
    busA.imem_ready = 1'b0;
    advA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (busA.imem_req !== 1'b1 || busA.imem_addr !== 32'h0040_0000) begin bad++; $display("[TB] FAIL wait_req_stable[%0d]: got req=%b addr=%h expected 1/00400000", i, busA.imem_req, busA.imem_addr); end
      total++; if (validA !== 1'b0 || retiredA !== 32'd8) begin bad++; $display("[TB] FAIL wait_advance_ignored[%0d]: got valid=%b retired=%0d expected 0/8", i, validA, retiredA); end
    end
    advA = 1'b0;
    busA.imem_ready = 1'b1;
    busA.imem_data  = 32'h8C88_0004;
    step();
    total++; if (validA !== 1'b1 || instrA !== 32'h8C88_0004 || opA !== 6'd35) begin bad++; $display("[TB] FAIL late_ready: got valid=%b instr=%h op=%0d expected 1/8c880004/35", validA, instrA, opA); end
    busA.imem_data = 32'hDEAD_BEEF;
    step();
    busA.imem_ready = 1'b0;
    total++; if (instrA !== 32'h8C88_0004 || busA.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL ready_in_exec: got instr=%h req=%b expected 8c880004/0", instrA, busA.imem_req); end
    advA = 1'b1;
    step();
    advA = 1'b0;
    total++; if (busA.imem_addr !== 32'h0040_0004 || retiredA !== 32'd9) begin bad++; $display("[TB] FAIL late_retire: got addr=%h retired=%0d expected 00400004/9", busA.imem_addr, retiredA); end
  endtask

  task automatic test_reset_mid_fetch();
    busA.imem_ready = 1'b1;
    busA.imem_data  = 32'h1234_5678;
    reset_n = 1'b0;
    #1;
    total++; if (busA.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL async_req_drop: got %b expected 0", busA.imem_req); end
    total++; if (busA.imem_addr !== 32'h0040_0000 || retiredA !== 32'd0) begin bad++; $display("[TB] FAIL async_pc_reset: got addr=%h retired=%0d expected 00400000/0", busA.imem_addr, retiredA); end
    step();
    total++; if (instrA !== 32'd0 || validA !== 1'b0) begin bad++; $display("[TB] FAIL no_ir_in_reset: got instr=%h valid=%b expected 0/0", instrA, validA); end
    busA.imem_ready = 1'b0;
    reset_n = 1'b1;
    step();
    total++; if (busA.imem_req !== 1'b1 || busA.imem_addr !== 32'h0040_0000) begin bad++; $display("[TB] FAIL refetch_after_reset: got req=%b addr=%h expected 1/00400000", busA.imem_req, busA.imem_addr); end
  endtask

  task automatic test_wrap();
    total++; if (busB.imem_addr !== 32'hFFFF_FFFC || plus4B !== 32'd0 || busB.imem_req !== 1'b1) begin bad++; $display("[TB] FAIL top_pc: got addr=%h plus4=%h req=%b expected fffffffc/0/1", busB.imem_addr, plus4B, busB.imem_req); end
    busB.imem_ready = 1'b1;
    busB.imem_data  = 32'h2008_0001;
    step();
    busB.imem_ready = 1'b0;
    total++; if (validB !== 1'b1 || instrB !== 32'h2008_0001 || opB !== 6'd8) begin bad++; $display("[TB] FAIL top_fetch: got valid=%b instr=%h op=%0d expected 1/20080001/8", validB, instrB, opB); end
    advB = 1'b1;
    step();
    advB = 1'b0;
    total++; if (busB.imem_addr !== 32'h0000_0000 || retiredB !== 32'd1) begin bad++; $display("[TB] FAIL pc_wrap: got addr=%h retired=%0d expected 00000000/1", busB.imem_addr, retiredB); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    busA.imem_ready = 1'b0; busA.imem_data = 32'd0;
    busB.imem_ready = 1'b0; busB.imem_data = 32'd0;
    advA = 1'b0; jumpA = 1'b0; branchA = 1'b0; zeroA = 1'b0;
    advB = 1'b0; jumpB = 1'b0; branchB = 1'b0; zeroB = 1'b0;
    test_reset();
    test_ready_same_cycle();
    test_branch();
    test_jump_priority();
    test_delayed_ready();
    test_reset_mid_fetch();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
